stack_arbiter: RTL and testbench
================================

// Module: stack_arbiter
// PURPOSE
//   Shares one 8-deep LIFO stack (push/pop/data_in/data_out/full/empty) between two requesters (0, 1).
//   Round-robin arbitration; each op is launched only when legal (no push when full, no pop when empty).
//   Sits between the two client blocks and the stack; the stack instance itself is external.
// PARAMETERS
//   DATA_W  4  width of stack words, wdata and rdata
// PORTS
//   clk           in   1       rising-edge clock
//   rstN          in   1       asynchronous, active-low reset
//   req0/req1     in   1       request; held high until gnt
//   op0/op1       in   1       1=push, 0=pop; held stable with req
//   wdata0/wdata1 in   DATA_W  push data; held stable with req
//   gnt0/gnt1     out  1       one-cycle pulse: request accepted, may drop req next cycle
//   rvalid0/1     out  1       one-cycle pulse: pop result on rdata
//   rdata         out  DATA_W  pop result, shared; qualified by rvalid0/1
//   stk_push      out  1       to stack push
//   stk_pop       out  1       to stack pop
//   stk_din       out  DATA_W  to stack data_in
//   stk_dout      in   DATA_W  from stack data_out (registered in stack, valid cycle after pop)
//   stk_full      in   1       from stack full
//   stk_empty     in   1       from stack empty
// BEHAVIOUR
//   Reset: state=IDLE; last=1; all outputs 0 (gnt*, rvalid*, stk_push, stk_pop, stk_din, rdata).
//   Eligibility (IDLE only, current flags): reqN & (opN ? ~stk_full : ~stk_empty).
//   FSM: IDLE -> ISSUE -> (pop: RESP | push: IDLE); RESP -> IDLE.
//   IDLE: no eligible -> stay. One eligible -> win. Both eligible -> win = ~last.
//         Register win, op, wdata; go ISSUE.
//   ISSUE (1 cycle): exactly one of stk_push/stk_pop=1, stk_din=latched wdata, gnt<win>=1.
//         Update last<=win.
//   RESP (1 cycle): rvalid<win>=1, rdata=stk_dout (already updated by the stack).
//   Latency: req seen in IDLE at cycle T -> gnt and stack cmd at T+1 -> rvalid at T+2 (pop).
//   Throughput: push one per 2 cycles, pop one per 3 cycles.
//   Flags are stable in IDLE (stack updates at end of ISSUE), so no full/empty hazard.
//   stk_push and stk_pop are never both 1; the stack's push+pop swap mode is never used.
//   Ineligible requests stall (not dropped) until legal or until req drops; no gnt while stalled.
//   Both requesting, only one eligible: the eligible one wins regardless of last.
//   last is unchanged while no grant occurs.
//   rdata holds its last value outside RESP; rvalid0 & rvalid1 never both 1.
//   rstN low mid-op (ISSUE/RESP): immediate IDLE, outputs 0, pending rvalid discarded.
//   rstN low mid-op: the stack sees its own reset.
// CONFIGURATION
//   STACK_ARB_ERR_EN defined: adds port err  out  2.
//     err[N] set when reqN is ineligible in IDLE (pop while empty / push while full).
//     err is sticky; cleared only by rstN.
//   Undefined: err port and its logic are absent; behaviour otherwise identical.
// TESTING
//   1. Reset, req0 push 4'hA: gnt0 and stk_push at T+1, stk_din=A. req1 pop: rvalid1 at T+2, rdata=A, empty=1.
//   2. req0 and req1 push held 6 ops: grants alternate 0,1,0,1,0,1 (0 first after reset).
//   2. (cont.) Pops then return wdata in reverse order.
//   3. Fill 8 pushes; req0 push 4'h3 stalls with gnt0=0 while full.
//   3. (cont.) req1 pop -> rvalid1 with top value; then gnt0 and push of 3.
//   4. Empty stack, req0 pop + req1 push 4'h5 together: req1 wins (only eligible).
//   4. (cont.) Next, req0 gets rvalid0 with rdata=5.
//   5. Assert rstN=0 during RESP: rvalid never pulses, all outputs 0, next grant goes to requester 0.
//   6. STACK_ARB_ERR_EN: pop on empty -> err[0]=1 stays set after the op succeeds; cleared by rstN.

Source files
------------

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin sharing of one external 8-deep LIFO between two requesters.
// Ports: clk, rstN (async active-low); req0/1, op0/1 (1=push, 0=pop), wdata0/1 from clients;
//   gnt0/1, rvalid0/1, rdata to clients; stk_push, stk_pop, stk_din to the stack;
//   stk_dout, stk_full, stk_empty from the stack.
// Optional: define STACK_ARB_ERR_EN to add err[1:0], sticky flags for ineligible requests.
module stack_arbiter #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_din,
  input  logic [DATA_W-1:0] stk_dout,
  input  logic              stk_full,
  input  logic              stk_empty
`ifdef STACK_ARB_ERR_EN
  ,
  output logic [1:0]        err
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t            state_q, state_d;
  logic              last_q, last_d, win_q, win_d, push_q, push_d, pop_q, pop_d;
  logic [1:0]        gnt_q, gnt_d, rvalid_q, rvalid_d, elig;
  logic [DATA_W-1:0] din_q, din_d, rdata_q, rdata_d;
`ifdef STACK_ARB_ERR_EN
  logic [1:0]        err_q, err_d;
`endif
  always_comb begin
    elig     = {req1 & (op1 ? ~stk_full : ~stk_empty), req0 & (op0 ? ~stk_full : ~stk_empty)};
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    gnt_d    = 2'b00;
    rvalid_d = 2'b00;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    din_d    = din_q;
    rdata_d  = rdata_q;
`ifdef STACK_ARB_ERR_EN
    err_d    = err_q | ((state_q == IDLE) ? ({req1, req0} & ~elig) : 2'b00);
`endif
    case (state_q)
      IDLE: if (|elig) begin
        // requester 1 wins when it alone is eligible, or both are and 0 went last
        win_d   = elig[1] & (~elig[0] | ~last_q);
        gnt_d   = win_d ? 2'b10 : 2'b01;
        push_d  = win_d ? op1 : op0;
        pop_d   = ~(win_d ? op1 : op0);
        din_d   = win_d ? wdata1 : wdata0;
        state_d = ISSUE;
      end
      ISSUE: begin
        last_d   = win_q;
        rvalid_d = pop_q ? (win_q ? 2'b10 : 2'b01) : 2'b00;
        state_d  = pop_q ? RESP : IDLE;
      end
      RESP: begin
        rdata_d = stk_dout;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      win_q    <= 1'b0;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      din_q    <= '0;
      rdata_q  <= '0;
`ifdef STACK_ARB_ERR_EN
      err_q    <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      din_q    <= din_d;
      rdata_q  <= rdata_d;
`ifdef STACK_ARB_ERR_EN
      err_q    <= err_d;
`endif
    end
  end
  assign gnt0     = gnt_q[0];
  assign gnt1     = gnt_q[1];
  assign rvalid0  = rvalid_q[0];
  assign rvalid1  = rvalid_q[1];
  assign stk_push = push_q;
  assign stk_pop  = pop_q;
  assign stk_din  = din_q;
  // the stack's registered data_out only becomes valid during RESP, so pass it
  // straight through then and hold the captured copy otherwise
  assign rdata    = (state_q == RESP) ? stk_dout : rdata_q;
`ifdef STACK_ARB_ERR_EN
  assign err      = err_q;
`endif
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: randomized self-checking bench for stack_arbiter with a behavioural stack.
module tb_stack_arbiter;
  logic       clk = 0, rstN = 0, req0 = 0, req1 = 0, op0 = 0, op1 = 0;
  logic [3:0] wdata0 = 0, wdata1 = 0;
  logic       gnt0, gnt1, rvalid0, rvalid1, stk_push, stk_pop, stk_full, stk_empty;
  logic [3:0] rdata, stk_din, stk_dout;
`ifdef STACK_ARB_ERR_EN
  logic [1:0] err;
`endif
  int n_chk = 0, n_fail = 0;
  logic [3:0] q[$];
  bit exp_last = 1;

  stack_arbiter #(.DATA_W(4)) dut (
    .clk(clk), .rstN(rstN), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty)
`ifdef STACK_ARB_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  // external 8-deep LIFO with registered data_out
  logic [3:0] mem [8];
  logic [3:0] cnt;
  assign stk_full  = (cnt == 4'd8);
  assign stk_empty = (cnt == 4'd0);
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt <= 0;
      stk_dout <= 0;
    end else if (stk_push) begin
      mem[3'(cnt)] <= stk_din;
      cnt <= cnt + 4'd1;
    end else if (stk_pop) begin
      stk_dout <= mem[3'(cnt - 4'd1)];
      cnt <= cnt - 4'd1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rstN = 0; req0 = 0; req1 = 0;
    @(negedge clk);
    rstN = 1;
    q.delete();
    exp_last = 1;
  endtask

  // one arbitration round: predicts winner from the eligibility/round-robin rules and the model stack
  task automatic round(input bit r0, input bit o0, input logic [3:0] d0,
                       input bit r1, input bit o1, input logic [3:0] d1);
    bit e0, e1, any, w, o;
    logic [3:0] d, exp;
    logic [1:0] want;
    e0 = r0 && (o0 ? q.size() < 8 : q.size() > 0);
    e1 = r1 && (o1 ? q.size() < 8 : q.size() > 0);
    any = e0 || e1;
    w = (e0 && e1) ? !exp_last : e1;
    o = w ? o1 : o0;
    d = w ? d1 : d0;
    @(negedge clk);
    req0 = r0; op0 = o0; wdata0 = d0; req1 = r1; op1 = o1; wdata1 = d1;
    @(negedge clk);
    want = any ? (w ? 2'b10 : 2'b01) : 2'b00;
    n_chk++;
    if ({gnt1, gnt0} !== want) begin
      n_fail++; $display("FAIL round_gnt: got %b want %b", {gnt1, gnt0}, want);
    end
    want = any ? {o, !o} : 2'b00;
    n_chk++;
    if ({stk_push, stk_pop} !== want) begin
      n_fail++; $display("FAIL round_cmd: push/pop got %b want %b", {stk_push, stk_pop}, want);
    end
    n_chk++;
    if ({rvalid1, rvalid0} !== 2'b00) begin
      n_fail++; $display("FAIL round_rvalid_early: got %b want 00", {rvalid1, rvalid0});
    end
    if (any) begin
      n_chk++;
      if (stk_din !== d) begin
        n_fail++; $display("FAIL round_din: got %h want %h", stk_din, d);
      end
    end
    req0 = 0; req1 = 0;
    if (any) begin
      exp_last = w;
      if (o) q.push_back(d);
      else begin
        exp = q.pop_back();
        @(negedge clk);
        want = w ? 2'b10 : 2'b01;
        n_chk++;
        if ({rvalid1, rvalid0} !== want) begin
          n_fail++; $display("FAIL round_rvalid: got %b want %b", {rvalid1, rvalid0}, want);
        end
        n_chk++;
        if (rdata !== exp) begin
          n_fail++; $display("FAIL round_rdata: got %h want %h", rdata, exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    rstN = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({gnt0, gnt1, rvalid0, rvalid1, stk_push, stk_pop, stk_din, rdata} !== 14'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0",
                         {gnt0, gnt1, rvalid0, rvalid1, stk_push, stk_pop, stk_din, rdata});
    end
`ifdef STACK_ARB_ERR_EN
    n_chk++;
    if (err !== 2'b00) begin
      n_fail++; $display("FAIL reset_err: got %b want 00", err);
    end
`endif
    rstN = 1;
    q.delete();
    exp_last = 1;
  endtask

  task automatic test_basic();
    round(1, 1, 4'hA, 0, 0, 4'h0);
    round(0, 0, 4'h0, 1, 0, 4'h0);
    n_chk++;
    if (stk_empty !== 1'b1) begin
      n_fail++; $display("FAIL basic_empty: got %b want 1", stk_empty);
    end
  endtask

  task automatic test_alternate();
    logic [3:0] d[2];
    bit seen, w;
    d[0] = 4'($urandom_range(0, 15));
    d[1] = 4'($urandom_range(0, 15));
    @(negedge clk);
    req0 = 1; req1 = 1; op0 = 1; op1 = 1; wdata0 = d[0]; wdata1 = d[1];
    for (int k = 0; k < 6; k++) begin
      seen = 0;
      for (int t = 0; t < 4 && !seen; t++) begin
        @(negedge clk);
        seen = gnt0 | gnt1;
      end
      w = !exp_last;
      n_chk++;
      if (!seen || {gnt1, gnt0} !== (w ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL alt_gnt%0d: got %b want %b", k, {gnt1, gnt0}, w ? 2'b10 : 2'b01);
      end
      n_chk++;
      if (stk_din !== d[w]) begin
        n_fail++; $display("FAIL alt_din%0d: got %h want %h", k, stk_din, d[w]);
      end
      q.push_back(d[w]);
      exp_last = w;
      d[w] = 4'($urandom_range(0, 15));
      if (w) wdata1 = d[1]; else wdata0 = d[0];
      if (k == 5) begin req0 = 0; req1 = 0; end
    end
    for (int k = 0; k < 6; k++) begin
      w = 1'($urandom_range(0, 1));
      round(!w, 0, 4'h0, w, 0, 4'h0);
    end
  endtask

  task automatic test_full();
    logic [3:0] exp;
    bit seen;
    for (int k = 0; k < 8; k++)
      round(k % 2 == 0, 1, 4'($urandom_range(0, 15)), k % 2 == 1, 1, 4'($urandom_range(0, 15)));
    @(negedge clk);
    req0 = 1; op0 = 1; wdata0 = 4'h3;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (gnt0 !== 1'b0 || stk_push !== 1'b0) begin
        n_fail++; $display("FAIL full_stall: gnt0/push got %b%b want 00", gnt0, stk_push);
      end
    end
    req1 = 1; op1 = 0;
    @(negedge clk);
    n_chk++;
    if ({gnt1, gnt0, stk_pop} !== 3'b101) begin
      n_fail++; $display("FAIL full_pop_gnt: gnt1,gnt0,pop got %b want 101", {gnt1, gnt0, stk_pop});
    end
    req1 = 0;
    exp = q.pop_back();
    exp_last = 1;
    @(negedge clk);
    n_chk++;
    if (rvalid1 !== 1'b1 || rdata !== exp) begin
      n_fail++; $display("FAIL full_pop_data: rvalid1 %b rdata %h want 1 %h", rvalid1, rdata, exp);
    end
    seen = 0;
    for (int t = 0; t < 4 && !seen; t++) begin
      @(negedge clk);
      seen = gnt0;
    end
    n_chk++;
    if (!seen || stk_push !== 1'b1 || stk_din !== 4'h3) begin
      n_fail++; $display("FAIL full_retry: gnt0 %b push %b din %h want 1 1 3", gnt0, stk_push, stk_din);
    end
    req0 = 0;
    q.push_back(4'h3);
    exp_last = 0;
    for (int k = 0; k < 8; k++) begin
      seen = 1'($urandom_range(0, 1));
      round(!seen, 0, 4'h0, seen, 0, 4'h0);
    end
  endtask

  task automatic test_priority();
    round(1, 0, 4'h0, 1, 1, 4'h5);
    round(1, 0, 4'h0, 0, 0, 4'h0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++)
      round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
  endtask

  task automatic test_reset_mid();
    round(0, 0, 4'h0, 1, 1, 4'h9);
    @(negedge clk);
    req0 = 1; op0 = 0;
    @(negedge clk);
    n_chk++;
    if (gnt0 !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_gnt: got %b want 1", gnt0);
    end
    req0 = 0;
    @(posedge clk);
    #1 rstN = 0;
    q.delete();
    exp_last = 1;
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if ({gnt0, gnt1, rvalid0, rvalid1, stk_push, stk_pop, stk_din, rdata} !== 14'd0) begin
        n_fail++; $display("FAIL rst_mid_outputs: got %b want 0",
                           {gnt0, gnt1, rvalid0, rvalid1, stk_push, stk_pop, stk_din, rdata});
      end
    end
    rstN = 1;
    @(negedge clk);
    n_chk++;
    if ({rvalid1, rvalid0} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_rvalid: got %b want 00", {rvalid1, rvalid0});
    end
    round(1, 1, 4'h1, 1, 1, 4'h2);
  endtask

`ifdef STACK_ARB_ERR_EN
  task automatic test_err();
    do_reset();
    round(1, 0, 4'h0, 0, 0, 4'h0);
    n_chk++;
    if (err !== 2'b01) begin
      n_fail++; $display("FAIL err_set: got %b want 01", err);
    end
    round(0, 0, 4'h0, 1, 1, 4'h7);
    round(1, 0, 4'h0, 0, 0, 4'h0);
    n_chk++;
    if (err !== 2'b01) begin
      n_fail++; $display("FAIL err_sticky: got %b want 01", err);
    end
    do_reset();
    n_chk++;
    if (err !== 2'b00) begin
      n_fail++; $display("FAIL err_clear: got %b want 00", err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_full();
    test_priority();
    test_random();
    test_reset_mid();
`ifdef STACK_ARB_ERR_EN
    test_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
